servo_ramp_multi: RTL

//   Multi-channel servo PWM generator with per-frame position ramping. Each channel holds a position

---
 rtl/servo_ramp_multi.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/servo_ramp_multi.sv
// servo_ramp_multi
//   Multi-channel servo PWM generator with per-frame position ramping.
//   Each channel keeps a position index. The index moves by at most one unit per PWM frame,
//   either by manual up/down control or by seeking a host-loaded target. The index is
//   converted to a pulse width, and each channel drives a registered, glitch-free PWM output.
//   A 16-bit status word for a selectable channel feeds the display/readback path.
//
// Ports
//   mclk          system clock
//   rst           synchronous reset, active high
//   tick_en       frame-time tick enable; the frame counter advances only when high
//   dir[NUM_CH]   manual mode direction (1 = up, 0 = down)
//   freeze[NUM_CH] hold position; overrides both modes
//   mode[NUM_CH]  0 = manual ramp, 1 = seek target
//   tgt_valid / tgt_ready / tgt_ch / tgt_pos   target load handshake
//   sel           status channel select
//   pwm_out       servo pulse outputs
//   pos_flat      current positions, ch0 in the LSBs
//   at_limit      position is 0 or POS_MAX
//   frame_strobe  one-cycle pulse after each frame wrap
//   status_out    {01,00,p[7:4],00,p[3:0],d,f} for channel sel, updated at frame wrap
module servo_ramp_multi #(
  parameter int NUM_CH    = 4,
  parameter int FRAME     = 20000,
  parameter int CNT_W     = 15,
  parameter int POS_W     = 8,
  parameter int POS_MAX   = 250,
  parameter int PULSE_MIN = 1000,
  parameter int STEP      = 4,
  localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    mclk,
  input  logic                    rst,
  input  logic                    tick_en,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       freeze,
  input  logic [NUM_CH-1:0]       mode,
  input  logic                    tgt_valid,
  output logic                    tgt_ready,
  input  logic [SEL_W-1:0]        tgt_ch,
  input  logic [POS_W-1:0]        tgt_pos,
  input  logic [SEL_W-1:0]        sel,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH*POS_W-1:0] pos_flat,
  output logic [NUM_CH-1:0]       at_limit,
  output logic                    frame_strobe,
  output logic [15:0]             status_out
);

  localparam int WID_W = $clog2(PULSE_MIN + POS_MAX * STEP + 1);
  localparam int CMP_W = (WID_W > CNT_W) ? WID_W : CNT_W;
  localparam logic [POS_W-1:0] POS_MAX_V = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q;
  logic [15:0]      status_q;
  logic             wrap;
  logic             load;
  logic [POS_W-1:0] tgt_clamped;

  // Next-cycle position and current target of every channel, used by the status mux.
  logic [NUM_CH-1:0][POS_W-1:0] pos_nxt_all;
  logic [NUM_CH-1:0][POS_W-1:0] tgt_all;

  assign wrap        = tick_en && (cnt_q == CNT_W'(FRAME - 1));
  assign tgt_ready   = !rst;
  assign load        = tgt_valid && tgt_ready;
  assign tgt_clamped = (tgt_pos > POS_MAX_V) ? POS_MAX_V : tgt_pos;

  always_comb begin
    cnt_d = cnt_q;
    if (tick_en) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [POS_W-1:0] pos_q, pos_d;
    logic [POS_W-1:0] tgt_q, tgt_d;
    logic [WID_W-1:0] width_q, width_d;
    logic             pwm_q;

    // Saturating one-unit step per frame; freeze wins over either mode.
    always_comb begin
      pos_d = pos_q;
      if (wrap && !freeze[gi]) begin
        if (!mode[gi]) begin
          if (dir[gi] && (pos_q < POS_MAX_V)) begin
            pos_d = pos_q + POS_ONE;
          end else if (!dir[gi] && (pos_q != '0)) begin
            pos_d = pos_q - POS_ONE;
          end
        end else begin
          if (tgt_q > pos_q) begin
            pos_d = pos_q + POS_ONE;
          end else if (tgt_q < pos_q) begin
            pos_d = pos_q - POS_ONE;
          end
        end
      end
    end

    // A load on the wrap cycle lands after the step, so that frame still seeks the old target.
    always_comb begin
      tgt_d = tgt_q;
      if (load && (int'(tgt_ch) == gi)) begin
        tgt_d = tgt_clamped;
      end
    end

    // Width only changes at the frame boundary, so a pulse is never cut or stretched mid-frame.
    always_comb begin
      width_d = width_q;
      if (wrap) begin
        width_d = WID_W'(PULSE_MIN) + WID_W'(pos_d) * WID_W'(STEP);
      end
    end

    always_ff @(posedge mclk) begin
      if (rst) begin
        pos_q   <= '0;
        tgt_q   <= '0;
        width_q <= WID_W'(PULSE_MIN);
        pwm_q   <= 1'b0;
      end else begin
        pos_q   <= pos_d;
        tgt_q   <= tgt_d;
        width_q <= width_d;
        // Compare against next-state values so the pulse starts on the cycle after the wrap.
        if (tick_en) begin
          pwm_q <= (CMP_W'(cnt_d) < CMP_W'(width_d));
        end
      end
    end

    assign pos_nxt_all[gi]              = pos_d;
    assign tgt_all[gi]                  = tgt_q;
    assign pos_flat[gi*POS_W +: POS_W]  = pos_q;
    assign at_limit[gi]                 = (pos_q == '0) || (pos_q == POS_MAX_V);
    assign pwm_out[gi]                  = pwm_q;
  end

  // Status fields for the selected channel. In target mode, d reports whether the channel
  // still has to climb after this frame's step.
  logic [7:0] st_p;
  logic       st_d;
  logic       st_f;

  always_comb begin
    st_p = '0;
    st_d = 1'b0;
    st_f = 1'b0;
    if (int'(sel) < NUM_CH) begin
      st_p = 8'(pos_nxt_all[sel]);
      st_d = mode[sel] ? (tgt_all[sel] > pos_nxt_all[sel]) : dir[sel];
      st_f = freeze[sel];
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      status_q <= 16'h4000;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= wrap;
      if (wrap) begin
        status_q <= {2'b01, 2'b00, st_p[7:4], 2'b00, st_p[3:0], st_d, st_f};
      end
    end
  end

  assign frame_strobe = strobe_q;
  assign status_out   = status_q;

endmodule
